// File: rtl/cmac_pkg.sv
// Package: cmac_pkg
// Purpose: shared definitions for the complex accumulator that sits downstream
//          of the 3-multiplier complex product stage.
//   - width helpers for product, accumulator and term-counter widths
//   - accumulator state encoding
//   - default upstream multiplier latency
package cmac_pkg;

  // Upstream multiplier latency from operands to pr/pi, in clock cycles.
  localparam int DEFAULT_MULT_LAT = 6;

  // EMPTY: no partial frame held. ACCUM: at least one term of a frame summed.
  typedef enum logic {
    EMPTY = 1'b0,
    ACCUM = 1'b1
  } acc_state_e;

  // Full-precision complex product width: one growth bit for the
  // add/subtract inside the 3-multiplier structure.
  function automatic int calc_pwidth(input int awidth, input int bwidth);
    return awidth + bwidth + 1;
  endfunction

  // Accumulator width: enough headroom that acc_len terms can never wrap.
  function automatic int calc_accw(input int awidth, input int bwidth,
                                   input int acc_len);
    return calc_pwidth(awidth, bwidth) + $clog2(acc_len);
  endfunction

  // Term counter width: must be able to hold acc_len itself.
  function automatic int calc_cntw(input int acc_len);
    return $clog2(acc_len + 1);
  endfunction

endpackage

// File: rtl/cmac_accum_tag_delay.sv
// Module: tag_delay
// Purpose: fixed-depth shift register that carries the {valid,last} tags of a
//          term alongside the upstream multiplier pipeline, so the tags line
//          up with the products that emerge DEPTH cycles later.
// Ports:
//   clk   in   1      rising-edge clock
//   rst   in   1      synchronous active-high reset, clears every stage
//   din   in   W      tag word entering the pipe
//   dout  out  W      tag word delayed by DEPTH cycles
module tag_delay #(
  parameter int W     = 2,
  parameter int DEPTH = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] stages [DEPTH];

  // Clearing every stage on reset is what discards in-flight terms: products
  // that emerge afterwards arrive with zero tags and are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stages[i] <= '0;
      end
    end else begin
      stages[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign dout = stages[DEPTH-1];

endmodule

// File: rtl/cmac_accum.sv
// Module: cmac_accum
// Purpose: sums a frame of complex products (pr, pi) into one complex result
//          (dot product / correlation tap). The products carry no valid of
//          their own, so in_valid/in_last, driven alongside the multiplier
//          operands, are delayed by MULT_LAT cycles to meet their products.
//          The frame result is presented on a one-entry valid/ready register.
// Ports:
//   clk        in   1       rising-edge clock
//   rst        in   1       synchronous active-high reset
//   in_valid   in   1       term valid, same cycle as the multiplier operands
//   in_last    in   1       last term of the frame, qualified by in_valid
//   pr, pi     in   PWIDTH  signed real/imaginary product from the multiplier
//   out_valid  out  1       result register holds an unconsumed frame result
//   out_ready  in   1       downstream accepts when out_valid && out_ready
//   acc_r      out  ACCW    signed real frame sum
//   acc_i      out  ACCW    signed imaginary frame sum
//   acc_cnt    out  CNTW    number of terms in the presented frame
//   overrun    out  1       sticky: a finished frame was dropped (output full)
module cmac_accum
  import cmac_pkg::*;
#(
  parameter  int AWIDTH   = 18,
  parameter  int BWIDTH   = 18,
  parameter  int MULT_LAT = DEFAULT_MULT_LAT,
  parameter  int ACC_LEN  = 64,
  localparam int PWIDTH   = calc_pwidth(AWIDTH, BWIDTH),
  localparam int ACCW     = calc_accw(AWIDTH, BWIDTH, ACC_LEN),
  localparam int CNTW     = calc_cntw(ACC_LEN)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_last,
  input  logic signed [PWIDTH-1:0] pr,
  input  logic signed [PWIDTH-1:0] pi,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [ACCW-1:0] acc_r,
  output logic signed [ACCW-1:0] acc_i,
  output logic [CNTW-1:0]        acc_cnt,
  output logic                   overrun
);

  acc_state_e             state;
  acc_state_e             state_next;
  logic                   v_d;
  logic                   l_d;
  logic signed [ACCW-1:0] term_r;
  logic signed [ACCW-1:0] term_i;
  logic signed [ACCW-1:0] acc_r_q;
  logic signed [ACCW-1:0] acc_i_q;
  logic signed [ACCW-1:0] sum_r;
  logic signed [ACCW-1:0] sum_i;
  logic [CNTW-1:0]        cnt_q;
  logic [CNTW-1:0]        cnt_inc;
  logic                   close;
  logic                   load_out;
  logic                   drop;

  tag_delay #(
    .W     (2),
    .DEPTH (MULT_LAT)
  ) u_tag_delay (
    .clk  (clk),
    .rst  (rst),
    .din  ({in_valid, in_last}),
    .dout ({v_d, l_d})
  );

  // Sign-extending size casts: the accumulator has log2(ACC_LEN) guard bits.
  assign term_r = ACCW'(pr);
  assign term_i = ACCW'(pi);

  // In EMPTY the first term is loaded rather than added, so a frame may start
  // in the cycle right after the previous one closed with no bubble.
  // cnt_inc is the term count including the current term; the frame closes on
  // in_last or when it reaches the maximum length.
  always_comb begin
    state_next = state;
    sum_r      = term_r;
    sum_i      = term_i;
    cnt_inc    = CNTW'(1);
    close      = 1'b0;
    if (state == ACCUM) begin
      sum_r   = acc_r_q + term_r;
      sum_i   = acc_i_q + term_i;
      cnt_inc = cnt_q + CNTW'(1);
    end
    if (v_d) begin
      close      = l_d || (cnt_inc == CNTW'(ACC_LEN));
      state_next = close ? EMPTY : ACCUM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // The partial sum is only meaningful in ACCUM; after a close its contents
  // are stale and get overwritten by the next load.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r_q <= '0;
      acc_i_q <= '0;
      cnt_q   <= '0;
    end else if (v_d) begin
      acc_r_q <= sum_r;
      acc_i_q <= sum_i;
      cnt_q   <= close ? '0 : cnt_inc;
    end
  end

  // A close can be accepted when the register is empty or is being drained
  // in this same cycle; otherwise the new result is lost and flagged.
  assign load_out = close && (!out_valid || out_ready);
  assign drop     = close && out_valid && !out_ready;

  // Output data only changes on a load, so it stays stable under
  // backpressure and keeps its last value after being consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      acc_r     <= '0;
      acc_i     <= '0;
      acc_cnt   <= '0;
      overrun   <= 1'b0;
    end else begin
      if (load_out) begin
        out_valid <= 1'b1;
        acc_r     <= sum_r;
        acc_i     <= sum_i;
        acc_cnt   <= cnt_inc;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (drop) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule
